uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte transmitter between NUM_REQ byte-producing requesters using round-robin arbitration.
- Sequences each transfer: selects a winner, presents its byte, issues a one-cycle start pulse, waits for the transmitter's done pulse, then acknowledges the winner.
- A watchdog aborts the transfer if done never arrives.
- Sits between the command/log sources and the uart_tx instance.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/rr_pick.sv | 51 +++++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants and types for the UART transmit arbiter:
//                byte width, default watchdog depth and one-hot FSM codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Width of one UART payload byte
    localparam int UART_BYTE_W         = 8;

    // Default watchdog depth; must exceed one full frame at the slowest baud
    localparam int DEFAULT_TIMEOUT_CYC = 256;

    // One-hot state codes for the transfer sequencer
    localparam int              ST_W      = 4;
    localparam logic [ST_W-1:0] ST_IDLE   = 4'b0001;
    localparam logic [ST_W-1:0] ST_LAUNCH = 4'b0010;
    localparam logic [ST_W-1:0] ST_WAIT   = 4'b0100;
    localparam logic [ST_W-1:0] ST_ACK    = 4'b1000;

    typedef enum logic [ST_W-1:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_ACK    = ST_ACK
    } arb_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Searches the request
//                vector starting one position above the last grant, wrapping
//                around, and returns the first asserted index.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o
);

    // Wide enough to hold base + offset (< 2*NUM_REQ) without overflow
    localparam int SUM_W = IDX_W + 2;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [SUM_W-1:0]     w_base_raw;
    logic [SUM_W-1:0]     w_base;
    logic [SUM_W-1:0]     w_off;
    logic [SUM_W-1:0]     w_sum;

    // Doubling the vector turns the wrap-around search into a plain slice
    assign w_dbl      = {req_i, req_i};
    assign w_base_raw = SUM_W'(last_i) + SUM_W'(1);
    assign w_base     = (w_base_raw >= SUM_W'(NUM_REQ)) ? '0 : w_base_raw;
    assign w_rot      = w_dbl[w_base +: NUM_REQ];

    // Lowest set bit of the rotated vector is the nearest requester after last
    always_comb begin
        w_off = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = SUM_W'(j);
            end
        end
    end

    assign w_sum   = w_base + w_off;
    assign idx_o   = (w_sum >= SUM_W'(NUM_REQ)) ? IDX_W'(w_sum - SUM_W'(NUM_REQ))
                                                : IDX_W'(w_sum);
    assign valid_o = |req_i;

endmodule : rr_pick
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one uart_tx byte transmitter between NUM_REQ
//                requesters. Round-robin grant, one-cycle start pulse, waits
//                for the transmitter's done pulse (guarded by a watchdog),
//                then acknowledges the served requester for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_i,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] data_i,
    output logic [NUM_REQ-1:0]             ack_o,
    output logic                           err_o,
    output logic                           busy_o,
    output logic                           tx_en_o,
    output logic [UART_BYTE_W-1:0]         tx_data_o,
    input  logic                           tx_done_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_e               state_q, state_d;
    logic [IDX_W-1:0]         sel_q, sel_d;
    logic [IDX_W-1:0]         last_q, last_d;
    logic [CNT_W-1:0]         wd_q, wd_d;
    logic [NUM_REQ-1:0]       ack_q, ack_d;
    logic                     err_q, err_d;
    logic                     busy_q, busy_d;
    logic                     tx_en_q, tx_en_d;
    logic [UART_BYTE_W-1:0]   tx_data_q, tx_data_d;

    logic                     w_pick_valid;
    logic [IDX_W-1:0]         w_pick_idx;
    logic [UART_BYTE_W-1:0]   w_pick_byte;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .valid_o (w_pick_valid),
        .idx_o   (w_pick_idx)
    );

    // Byte of the would-be winner, captured only when the grant is made
    always_comb begin
        w_pick_byte = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_idx == IDX_W'(k)) begin
                w_pick_byte = data_i[k*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    // Next-state and registered-output logic of the transfer sequencer
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        wd_d      = wd_q;
        ack_d     = '0;
        err_d     = 1'b0;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (w_pick_valid) begin
                    sel_d     = w_pick_idx;
                    tx_data_d = w_pick_byte;
                    tx_en_d   = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over a same-cycle watchdog expiry
                if (tx_done_i) begin
                    ack_d[sel_q] = 1'b1;
                    state_d      = S_ACK;
                end else if (wd_q == WD_LAST) begin
                    ack_d[sel_q] = 1'b1;
                    err_d        = 1'b1;
                    state_d      = S_ACK;
                end else begin
                    wd_d = wd_q + CNT_W'(1);
                end
            end
            S_ACK: begin
                last_d  = sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset aborts any transfer without an ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= '0;
            last_q    <= LAST_RST;
            wd_q      <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            wd_q      <= wd_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign ack_o     = ack_q;
    assign err_o     = err_q;
    assign busy_o    = busy_q;
    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench. Instance A drives a behavioural uart_tx
//                (10-clock bit period, 256-cycle watchdog); instance B has a
//                16-cycle watchdog and a hand-driven done line.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int BIT_CLK = 10;

    typedef struct {
        logic [3:0] ack;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_a = '0,  req_b = '0;
    logic [31:0] data_a = '0, data_b = '0;
    logic [3:0]  ack_a, ack_b;
    logic        err_a, err_b, busy_a, busy_b, tx_en_a, tx_en_b;
    logic [7:0]  tx_data_a, tx_data_b;
    logic        done_a = 1'b0, done_b = 1'b0;

    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [9:0]  last_frame = '0;

    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(256)) u_dut_a (
        .clk(clk), .rst(rst), .req_i(req_a), .data_i(data_a),
        .ack_o(ack_a), .err_o(err_a), .busy_o(busy_a),
        .tx_en_o(tx_en_a), .tx_data_o(tx_data_a), .tx_done_i(done_a)
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CYC(16)) u_dut_b (
        .clk(clk), .rst(rst), .req_i(req_b), .data_i(data_b),
        .ack_o(ack_b), .err_o(err_b), .busy_o(busy_b),
        .tx_en_o(tx_en_b), .tx_data_o(tx_data_b), .tx_done_i(done_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor for instance A
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_a != 4'b0) begin
                if (exp_a.size() == 0) begin
                    chk("ack_a_unexpected", {28'b0, ack_a}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_a.pop_front();
                    chk("ack_a", {28'b0, ack_a}, {28'b0, e.ack});
                    chk("err_a", {31'b0, err_a}, {31'b0, e.err});
                end
            end else if (err_a) begin
                chk("err_a_orphan", {31'b0, err_a}, 32'h0);
            end
        end
    end

    // Scoreboard monitor for instance B
    always @(negedge clk) begin
        if (!rst) begin
            if (ack_b != 4'b0) begin
                if (exp_b.size() == 0) begin
                    chk("ack_b_unexpected", {28'b0, ack_b}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_b.pop_front();
                    chk("ack_b", {28'b0, ack_b}, {28'b0, e.ack});
                    chk("err_b", {31'b0, err_b}, {31'b0, e.err});
                end
            end else if (err_b) begin
                chk("err_b_orphan", {31'b0, err_b}, 32'h0);
            end
        end
    end

    // Behavioural uart_tx for instance A: start bit, 8 data LSB first, stop
    initial begin
        logic [7:0] byte_l;
        logic [9:0] fr;
        int         unst;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (!rst && tx_en_a) begin
                byte_l  = tx_data_a;
                fr      = '0;
                unst    = 0;
                aborted = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    fr[b] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : byte_l[b-1];
                    for (int c = 0; c < BIT_CLK; c++) begin
                        @(negedge clk);
                        if (rst) aborted = 1'b1;
                        if (aborted) break;
                        if (tx_data_a !== byte_l) unst++;
                        if (b == 0 && c == 0) chk("tx_en_pulse", {31'b0, tx_en_a}, 32'h0);
                    end
                    if (aborted) break;
                end
                if (!aborted) begin
                    last_frame = fr;
                    chk("tx_data_stable", unst, 32'h0);
                    done_a = 1'b1;
                    @(negedge clk);
                    done_a = 1'b0;
                    chk("ack_latency", {31'b0, |ack_a}, 32'h1);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        exp_a.delete();
        exp_b.delete();
        rst = 1'b0;
    endtask

    task automatic wait_ack_a(input int k);
        int t = 0;
        while (!ack_a[k] && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("ack_a_wait_timeout", 32'h0, 32'h1);
        req_a[k] = 1'b0;
    endtask

    task automatic wait_en(input bit use_b);
        int t = 0;
        while (!(use_b ? tx_en_b : tx_en_a) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) chk("tx_en_wait_timeout", 32'h0, 32'h1);
    endtask

    initial begin
        int cnt;
        int t;
        int k;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ack",     {28'b0, ack_a},   32'h0);
        chk("rst_err",     {31'b0, err_a},   32'h0);
        chk("rst_busy",    {31'b0, busy_a},  32'h0);
        chk("rst_tx_en",   {31'b0, tx_en_a}, 32'h0);
        chk("rst_tx_data", {24'b0, tx_data_a}, 32'h0);
        do_reset();

        // Single request from requester 2, byte A5
        data_a = 32'h00A5_0000;
        exp_a.push_back('{4'b0100, 1'b0});
        req_a = 4'b0100;
        @(negedge clk);
        chk("tx_en_latency", {31'b0, tx_en_a}, 32'h1);
        chk("tx_data_a5",    {24'b0, tx_data_a}, 32'hA5);
        wait_ack_a(2);
        chk("frame_a5", {22'b0, last_frame}, {22'b0, 10'b11_0100_1010});

        // All four continuously requesting after reset: 0,1,2,3,0
        do_reset();
        data_a = 32'h1312_1110;
        exp_a.push_back('{4'b0001, 1'b0});
        exp_a.push_back('{4'b0010, 1'b0});
        exp_a.push_back('{4'b0100, 1'b0});
        exp_a.push_back('{4'b1000, 1'b0});
        exp_a.push_back('{4'b0001, 1'b0});
        req_a = 4'b1111;
        cnt = 0;
        t = 0;
        while (cnt < 5 && t < 5000) begin
            @(negedge clk);
            t++;
            if (ack_a != 4'b0) cnt++;
        end
        req_a = 4'b0;
        chk("rr_five_acks", cnt, 32'd5);
        repeat (3) @(negedge clk);
        chk("rr_idle_after", {31'b0, busy_a}, 32'h0);

        // After reset 1010 serves requester 1 before 3
        do_reset();
        data_a = 32'h4400_2200;
        exp_a.push_back('{4'b0010, 1'b0});
        exp_a.push_back('{4'b1000, 1'b0});
        req_a = 4'b1010;
        wait_ack_a(1);
        wait_ack_a(3);

        // Asynchronous reset in WAIT, then re-serve from requester 0
        do_reset();
        data_a = 32'h0077_0066;
        req_a = 4'b0100;
        wait_en(1'b0);
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy",    {31'b0, busy_a},   32'h0);
        chk("arst_tx_en",   {31'b0, tx_en_a},  32'h0);
        chk("arst_ack",     {28'b0, ack_a},    32'h0);
        chk("arst_tx_data", {24'b0, tx_data_a}, 32'h0);
        req_a = 4'b0101;
        repeat (2) @(negedge clk);
        exp_a.delete();
        exp_a.push_back('{4'b0001, 1'b0});
        exp_a.push_back('{4'b0100, 1'b0});
        rst = 1'b0;
        wait_ack_a(0);
        wait_ack_a(2);

        // Instance B: watchdog expiry after 16 WAIT cycles
        do_reset();
        data_b = 32'h4433_2211;
        exp_b.push_back('{4'b0001, 1'b1});
        req_b = 4'b0001;
        wait_en(1'b1);
        chk("b_tx_data", {24'b0, tx_data_b}, 32'h11);
        k = 0;
        while (ack_b == 4'b0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        req_b = 4'b0;
        chk("timeout_wait_cycles", k - 1, 32'd16);
        @(negedge clk);
        chk("timeout_busy_clear", {31'b0, busy_b}, 32'h0);

        // Done collides with the last watchdog cycle: done wins
        exp_b.push_back('{4'b0010, 1'b0});
        req_b = 4'b0010;
        wait_en(1'b1);
        repeat (16) @(negedge clk);
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("collide_ack", {28'b0, ack_b}, 32'h2);
        chk("collide_err", {31'b0, err_b}, 32'h0);
        req_b = 4'b0;
        repeat (2) @(negedge clk);

        // Spurious done while IDLE has no effect
        done_b = 1'b1;
        @(negedge clk);
        done_b = 1'b0;
        chk("spur_busy",  {31'b0, busy_b},  32'h0);
        chk("spur_tx_en", {31'b0, tx_en_b}, 32'h0);
        @(negedge clk);
        chk("spur_ack",   {28'b0, ack_b},   32'h0);

        repeat (4) @(negedge clk);
        chk("exp_a_drained", exp_a.size(), 32'h0);
        chk("exp_b_drained", exp_b.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
